// File: rtl/rr_arbiter4_enc.sv
// Purpose: 4-requester round-robin arbiter with registered grant index, valid flag and hold timeout.
// Latency: 1 cycle from request to grant; every release is followed by at least one idle cycle.
// Backpressure: grant is held until done, request drop, or the hold limit forces a release.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   req[3:0]     request vector, bit i is requester i
//   done         release strobe from the granted requester (ignored while idle)
//   grant_valid  a grant is active this cycle (gates the downstream decoder)
//   grant_idx    index of the granted requester (downstream decoder select)
//   timeout      one-cycle pulse: the previous grant was force-released by the hold limit

module rr_arbiter4_enc #(
    parameter int HOLD_MAX = 8,  // max cycles a grant is held; 0 disables the limit
    parameter int CNT_W    = 4   // hold counter width; HOLD_MAX must fit as 2^CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value seen during the last permitted cycle of a grant.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             grant_valid_q;
    logic [1:0]       grant_idx_q;
    logic             timeout_q;

    // Next winner when leaving IDLE.
    logic [7:0]       req_dbl;
    logic [3:0]       req_rot;
    logic [1:0]       win_off;
    logic [1:0]       grant_idx_d;

    // Release decision while in GRANT.
    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic             release_d;
    logic             timeout_d;

    // Rotate the request vector so that bit 0 is the requester at ptr;
    // the first set bit of the rotated vector is the offset from ptr.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr_q +: 4];

    always_comb begin
        win_off = 2'd3;
        if (req_rot[0]) begin
            win_off = 2'd0;
        end else if (req_rot[1]) begin
            win_off = 2'd1;
        end else if (req_rot[2]) begin
            win_off = 2'd2;
        end
    end

    // 2-bit add wraps naturally mod 4.
    assign grant_idx_d = ptr_q + win_off;

    // Priority: done beats a request drop, which beats the hold limit,
    // so a timeout only fires when the requester still wants the bus.
    assign rel_done  = done;
    assign rel_drop  = ~req[grant_idx_q];
    assign rel_hold  = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_d = rel_done | rel_drop | rel_hold;
    assign timeout_d = ~rel_done & ~rel_drop & rel_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= 2'd0;
            timeout_q     <= 1'b0;
        end else begin
            // Pulse output: only the release edge below may raise it.
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q       <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= grant_idx_d;
                        hold_cnt_q    <= '0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        // grant_idx is left alone; only the valid flag drops,
                        // which gives the downstream decoder its idle bubble.
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_idx_q + 2'd1;
                        timeout_q     <= timeout_d;
                    end else if (hold_cnt_q != '1) begin
                        // Saturate so an unlimited hold never wraps the count.
                        hold_cnt_q <= hold_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4_enc.sv
// Purpose: self-checking bench for rr_arbiter4_enc, two instances (hold limit 8 and unlimited).
// Latency: outputs compared half a cycle after each rising edge against a cycle-level model.
// Backpressure: n/a; stimulus is directed scenarios followed by randomized bursts.

module tb_rr_arbiter4_enc;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic       gv8, to8, gv0, to0;
    logic [1:0] idx8, idx0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: [0] = HOLD_MAX 8, [1] = HOLD_MAX 0.
    int hm[2] = '{8, 0};
    bit m_busy[2];
    int m_idx[2];
    int m_ptr[2];
    int m_age[2];   // cycles the current grant has been visible, counting this one
    bit m_to[2];

    rr_arbiter4_enc #(.HOLD_MAX(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(gv8), .grant_idx(idx8), .timeout(to8)
    );

    rr_arbiter4_enc #(.HOLD_MAX(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(gv0), .grant_idx(idx0), .timeout(to0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
            m_ptr[k]  = 0;
            m_age[k]  = 0;
            m_to[k]   = 1'b0;
        end
    endfunction

    // Advance the model by one rising edge using the current req/done.
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            m_to[k] = 1'b0;
            if (m_busy[k]) begin
                bit rel  = 1'b0;
                bit tflg = 1'b0;
                if (done)                                 rel = 1'b1;
                else if (!req[m_idx[k]])                  rel = 1'b1;
                else if (hm[k] != 0 && m_age[k] == hm[k]) begin rel = 1'b1; tflg = 1'b1; end
                else                                      m_age[k]++;
                if (rel) begin
                    m_busy[k] = 1'b0;
                    m_ptr[k]  = (m_idx[k] + 1) % 4;
                    m_to[k]   = tflg;
                end
            end else if (req != 4'd0) begin
                bit found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && req[(m_ptr[k] + i) % 4]) begin
                        found    = 1'b1;
                        m_idx[k] = (m_ptr[k] + i) % 4;
                    end
                end
                m_busy[k] = 1'b1;
                m_age[k]  = 1;
            end
        end
    endfunction

    task automatic compare_all();
        check("grant_valid", 8, {3'b0, gv8},  {3'b0, m_busy[0]});
        check("grant_idx",   8, {2'b0, idx8}, 4'(m_idx[0]));
        check("timeout",     8, {3'b0, to8},  {3'b0, m_to[0]});
        check("grant_valid", 0, {3'b0, gv0},  {3'b0, m_busy[1]});
        check("grant_idx",   0, {2'b0, idx0}, 4'(m_idx[1]));
        check("timeout",     0, {3'b0, to0},  {3'b0, m_to[1]});
    endtask

    // One clock: model takes the edge, DUT outputs checked at the falling edge.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            model_edge();
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'd0;
        done = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Single requester, release by done, regrant after one bubble.
        req = 4'b0100;
        step(1);
        check("single_idx", 8, {2'b0, idx8}, 4'd2);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(2);

        // Rotation with all requesting, done on every grant.
        req = 4'b1111; done = 1'b0;
        step(1);
        for (int r = 0; r < 12; r++) begin
            done = m_busy[0];
            step(1);
        end
        done = 1'b0; req = 4'd0;
        step(2);

        // Wrap: serve 2 so ptr=3, then 0011 must go to 0 then 1.
        req = 4'b0100;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0; req = 4'b0011;
        step(1);
        check("wrap_first", 8, {2'b0, idx8}, 4'd0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(1);
        check("wrap_second", 8, {2'b0, idx8}, 4'd1);
        req = 4'd0;
        step(2);

        // Hold limit: requester 1 held with no done; unlimited instance never times out.
        req = 4'b0010;
        step(100);
        req = 4'd0;
        step(2);

        // done on the edge that would time out.
        req = 4'b0010;
        step(8);
        done = 1'b1;
        step(1);
        done = 1'b0; req = 4'd0;
        step(2);

        // Request drop on the edge that would time out.
        req = 4'b0010;
        step(8);
        req = 4'd0;
        step(3);

        // Asynchronous reset in the middle of a grant to 2.
        req = 4'b0100;
        step(3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_gv",  8, {3'b0, gv8},  4'd0);
        check("rst_idx", 8, {2'b0, idx8}, 4'd0);
        check("rst_to",  8, {3'b0, to8},  4'd0);
        check("rst_idx", 0, {2'b0, idx0}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        step(1);
        check("post_rst_idx", 8, {2'b0, idx8}, 4'd0);
        req = 4'd0;
        step(2);

        // Randomized bursts: mostly stable requests so the hold limit is reached.
        for (int b = 0; b < 40; b++) begin
            req = 4'($urandom_range(0, 15));
            for (int c = 0; c < 14; c++) begin
                if ($urandom_range(0, 9) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
                done = ($urandom_range(0, 5) == 0);
                step(1);
            end
        end
        done = 1'b0; req = 4'd0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4_enc.md
Name: rr_arbiter4_enc

Overview:
- 4-requester round-robin arbiter. Output is a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the team's 2-to-4 decoder: grant_idx drives the decoder select, and grant_valid gates the decoder's one-hot output.
- Grants are held until the requester signals done, drops its request, or hits a programmable hold timeout.
- Priority rotates so the last-served requester becomes lowest priority.

Parameters:
- HOLD_MAX, default 8: maximum cycles a grant is held before forced release. 0 disables the timeout.
- CNT_W, default 4: hold-counter width. Requirement: HOLD_MAX <= 2^CNT_W.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i is requester i.
- done  input  1  release strobe from the currently granted requester. Sampled only while grant_valid=1.
- grant_valid  output  1  a grant is active this cycle.
- grant_idx  output  2  index of the granted requester. Feeds the decoder select.
- timeout  output  1  one-cycle pulse: the previous grant was force-released by the hold limit.

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - state=IDLE, grant_valid=0, grant_idx=2'b00, timeout=0.
  - Priority pointer ptr=0; hold_cnt=0.
- All outputs are registered. There is no combinational path from req or done to any output.
- States: IDLE, GRANT.
- IDLE:
  - req==0: stay in IDLE, grant_valid=0, grant_idx holds its last value.
  - req!=0: search order ptr, ptr+1, ptr+2, ptr+3, each mod 4; the first set bit wins.
  - Next edge: grant_valid=1, grant_idx=winner, hold_cnt=0, state=GRANT.
  - Latency from req asserted to grant_valid: 1 cycle.
- GRANT, evaluated each edge in priority order:
  - (a) done=1 → release, timeout=0.
  - (b) req[grant_idx]=0 → release, timeout=0.
  - (c) HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 → release, timeout=1 for exactly the next cycle.
  - (d) otherwise hold_cnt+1, stay in GRANT, grant_idx stable.
- Release actions:
  - state=IDLE, grant_valid=0, ptr=grant_idx+1 (3 wraps to 0).
  - grant_idx keeps its last value.
- Every release is followed by at least one IDLE cycle (grant_valid=0). This bubble guarantees the gated decoder output returns to 4'b0000 between grants.
- A grant lasts at most HOLD_MAX cycles. With HOLD_MAX=1, every grant lasts exactly 1 cycle and, unless done or the request drop occurs, ends with a timeout pulse.
- Simultaneous events:
  - done and timeout on the same edge: done wins, timeout stays 0.
  - Request drop and timeout on the same edge: treated as a drop, no timeout.
- Ignored inputs:
  - done while in IDLE is ignored.
  - Changes to other req bits during GRANT do not affect the current grant.
- timeout is deasserted in every cycle other than the one-cycle pulse.
- hold_cnt never wraps. It is cleared on entry to GRANT.

Test Plan:
- Reset: rst=1 mid-grant with grant_idx=2 → same cycle grant_valid=0, grant_idx=0, timeout=0. After release, req=4'b1111 → grant_idx=0 one cycle later.
- Single requester: req=4'b0100 from IDLE → grant_valid=1, grant_idx=2 after 1 edge. done=1 for one cycle → grant_valid=0 next cycle, then re-grant of idx 2 one cycle later.
- Rotation: req=4'b1111 held, done pulsed on each grant → grant_idx sequence 0,1,2,3,0. Each grant is separated by exactly one grant_valid=0 cycle.
- Fairness/wrap: ptr=3 (after serving idx 2), req=4'b0011 → grant idx 0. After release, req still 4'b0011 → grant idx 1.
- Timeout: HOLD_MAX=8, req=4'b0010 held, done=0 → grant_valid high exactly 8 cycles, then timeout=1 for 1 cycle with grant_valid=0.
- Conflicts: done=1 on the timeout edge → timeout stays 0. Request drop while granted (req[1] falls) → release next edge, no timeout. HOLD_MAX=0 with req held and no done for 100 cycles → grant held, timeout never asserts.
